// File: rtl/seeg_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// seeg_cmd_sequencer
//
// Command sequencer for the SEEG headstage SPI engine. On start it replays a
// programmable list of init register commands, then issues two pipeline-flush
// dummies, then loops CONVERT commands over the active channels (one frame per
// loop) until stopped. Commands leave on a valid/ready handshake.
//
// Ports:
//   S_AXI_ACLK     block clock
//   S_AXI_ARESETN  asynchronous active-low reset
//   start / stop   one-cycle control pulses (start ignored while busy,
//                  stop ignored while idle)
//   init_len       number of init entries to issue, latched on start
//   ch_count       channels per frame, latched on start (0 or >NUM_CH -> NUM_CH)
//   cfg_we/addr/wdata  init register file write port (honoured only when idle)
//   cmd_valid/cmd_ready/cmd_data  command handshake towards the SPI engine
//   frame_start    pulse the cycle after CONVERT(0) is accepted
//   busy           high whenever not idle
//   state_o        0 IDLE, 1 INIT, 2 FLUSH, 3 ACQ
//   frame_cnt      completed frames, wraps at 2^32
// ---------------------------------------------------------------------------
module seeg_cmd_sequencer #(
    parameter int          NUM_CH     = 32,
    parameter int          INIT_DEPTH = 16,
    parameter logic [15:0] FLUSH_CMD  = 16'hE800
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          start,
    input  logic                          stop,
    input  logic [$clog2(INIT_DEPTH):0]   init_len,
    input  logic [6:0]                    ch_count,
    input  logic                          cfg_we,
    input  logic [$clog2(INIT_DEPTH)-1:0] cfg_addr,
    input  logic [15:0]                   cfg_wdata,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [15:0]                   cmd_data,
    output logic                          frame_start,
    output logic                          busy,
    output logic [1:0]                    state_o,
    output logic [31:0]                   frame_cnt
);

    localparam int         AW       = $clog2(INIT_DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(INIT_DEPTH);
    localparam logic [6:0] NUM_CH_W = 7'(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_FLUSH = 2'd2,
        S_ACQ   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] idx_q, idx_d;      // init entry being presented
    logic [AW:0] len_q, len_d;      // latched, clamped init_len
    logic [6:0]  chc_q, chc_d;      // latched, clamped ch_count
    logic [5:0]  ch_q, ch_d;        // channel being presented in ACQ
    logic        flush_q, flush_d;  // 0: first dummy, 1: second dummy
    logic        stop_q, stop_d;    // stop seen, waiting for a safe exit point
    logic        frame_start_d;
    logic [31:0] frame_cnt_d;

    logic [15:0] init_mem [INIT_DEPTH];

    logic accept;
    logic stop_any;
    logic init_last;
    logic ch_last;

    assign accept    = cmd_valid && cmd_ready;
    assign stop_any  = stop || stop_q;   // a stop arriving with the accept counts too
    assign init_last = (idx_q == len_q - 1'b1);
    assign ch_last   = ({1'b0, ch_q} == chc_q - 7'd1);

    assign busy    = (state_q != S_IDLE);
    assign state_o = state_q;

    // NOTE: the register file has no reset; its contents survive reset and
    // are only defined once written.
    always_ff @(posedge S_AXI_ACLK) begin
        if (cfg_we && state_q == S_IDLE)
            init_mem[cfg_addr] <= cfg_wdata;
    end

    // NOTE: every sequential element uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            chc_q       <= '0;
            ch_q        <= '0;
            flush_q     <= 1'b0;
            stop_q      <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            chc_q       <= chc_d;
            ch_q        <= ch_d;
            flush_q     <= flush_d;
            stop_q      <= stop_d;
            frame_start <= frame_start_d;
            frame_cnt   <= frame_cnt_d;
        end
    end

    // cmd_valid/cmd_data are decoded from registered state, so they stay
    // stable while stalled and drop immediately on reset.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned (which would infer a latch).
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        chc_d         = chc_q;
        ch_d          = ch_q;
        flush_d       = flush_q;
        stop_d        = stop_q;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt;
        cmd_valid     = 1'b0;
        cmd_data      = 16'h0000;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = (init_len > DEPTH_W) ? DEPTH_W : init_len;
                    chc_d   = (ch_count == 7'd0 || ch_count > NUM_CH_W) ? NUM_CH_W : ch_count;
                    idx_d   = '0;
                    ch_d    = '0;
                    flush_d = 1'b0;
                    stop_d  = 1'b0;
                    state_d = (init_len == '0) ? S_FLUSH : S_INIT;
                end
            end

            S_INIT: begin
                cmd_valid = 1'b1;
                cmd_data  = init_mem[idx_q[AW-1:0]];
                if (stop) stop_d = 1'b1;
                if (accept) begin
                    if (stop_any) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                    end else if (init_last) begin
                        state_d = S_FLUSH;
                        flush_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_FLUSH: begin
                cmd_valid = 1'b1;
                cmd_data  = FLUSH_CMD;
                if (stop) stop_d = 1'b1;
                if (accept) begin
                    if (stop_any) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                    end else if (flush_q) begin
                        state_d = S_ACQ;
                        ch_d    = '0;
                    end else begin
                        flush_d = 1'b1;
                    end
                end
            end

            S_ACQ: begin
                cmd_valid = 1'b1;
                cmd_data  = {2'b00, ch_q, 8'h00};
                if (stop) stop_d = 1'b1;
                if (accept) begin
                    if (ch_q == 6'd0) frame_start_d = 1'b1;
                    if (ch_last) begin
                        // A stop only takes effect at a frame boundary.
                        frame_cnt_d = frame_cnt + 32'd1;
                        ch_d        = '0;
                        if (stop_any) begin
                            state_d = S_IDLE;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        ch_d = ch_q + 6'd1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_seeg_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_seeg_cmd_sequencer
//
// Scoreboard bench: each run pushes the full expected command stream (data,
// state, frame markers) into a queue; a negedge monitor pops on every accepted
// command and checks stalls, frame_start, frame_cnt and the stop exit.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seeg_cmd_sequencer;

    localparam int          NUM_CH     = 32;
    localparam int          INIT_DEPTH = 16;
    localparam int          AW         = 4;
    localparam logic [15:0] FLUSH_CMD  = 16'hE800;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW:0]   init_len = '0;
    logic [6:0]    ch_count = '0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [15:0]   cfg_wdata = '0;
    logic          cmd_ready = 1'b0;
    logic          cmd_valid;
    logic [15:0]   cmd_data;
    logic          frame_start;
    logic          busy;
    logic [1:0]    state_o;
    logic [31:0]   frame_cnt;

    always #5 clk = ~clk;

    seeg_cmd_sequencer #(
        .NUM_CH(NUM_CH), .INIT_DEPTH(INIT_DEPTH), .FLUSH_CMD(FLUSH_CMD)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .start(start), .stop(stop), .init_len(init_len), .ch_count(ch_count),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .frame_start(frame_start), .busy(busy), .state_o(state_o),
        .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic [15:0] data;
        logic [1:0]  st;
        bit          first;
        bit          last;
        bit          fin;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] mem_model [INIT_DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          frames_tot = 0;
    int          ready_pct = 100;
    bit          manual = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Backpressure generator.
    initial forever begin
        @(posedge clk); #1;
        if (!manual) cmd_ready = (int'($urandom_range(99)) < ready_pct);
    end

    // Monitor / scoreboard.
    bit          fs_pend = 1'b0;
    bit          fin_pend = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    int          model_frames = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            fs_pend = 1'b0; fin_pend = 1'b0; prev_stall = 1'b0; model_frames = 0;
        end else begin
            check("frame_start", 32'(frame_start), 32'(fs_pend));
            check("frame_cnt", frame_cnt, 32'(model_frames));
            if (fin_pend) check("busy_after_last", 32'(busy), 32'd0);
            if (prev_stall) begin
                check("valid_held", 32'(cmd_valid), 32'd1);
                check("data_held", 32'(cmd_data), 32'(prev_data));
            end
            fs_pend = 1'b0;
            fin_pend = 1'b0;
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd: got %0h expected no command at %0t", cmd_data, $time);
                end else begin
                    check("cmd_data", 32'(cmd_data), 32'(exp_q[0].data));
                    check("state_o", 32'(state_o), 32'(exp_q[0].st));
                    if (cmd_ready) begin
                        mon_e = exp_q.pop_front();
                        acc_cnt++;
                        fs_pend = mon_e.first;
                        fin_pend = mon_e.fin;
                        if (mon_e.last) model_frames++;
                    end
                end
            end
            prev_stall = cmd_valid && !cmd_ready;
            prev_data  = cmd_data;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", frame_cnt, 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_data", 32'(cmd_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        frames_tot = 0;
    endtask

    task automatic write_cfg(input int addr, input logic [15:0] data);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = addr[AW-1:0]; cfg_wdata = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        mem_model[addr] = data;
    endtask

    task automatic wait_acc(input int target);
        int t = 0;
        while (acc_cnt < target && t < 20000) begin
            @(posedge clk); #1; t++;
        end
        if (acc_cnt < target) check("accept_timeout", 32'(acc_cnt), 32'(target));
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        check("reach_idle", 32'(busy), 32'd0);
    endtask

    // Expected stream for a run: init list, two flushes, whole frames.
    task automatic push_run(input int eff_len, input int eff_ch, input int nframes);
        logic [15:0] w;
        for (int i = 0; i < eff_len; i++)
            exp_q.push_back('{data: mem_model[i], st: 2'd1, first: 1'b0, last: 1'b0, fin: 1'b0});
        for (int i = 0; i < 2; i++)
            exp_q.push_back('{data: FLUSH_CMD, st: 2'd2, first: 1'b0, last: 1'b0, fin: 1'b0});
        for (int f = 0; f < nframes; f++)
            for (int c = 0; c < eff_ch; c++) begin
                w = {2'b00, c[5:0], 8'h00};
                exp_q.push_back('{data: w, st: 2'd3, first: (c == 0), last: (c == eff_ch - 1),
                                  fin: (c == eff_ch - 1) && (f == nframes - 1)});
            end
    endtask

    task automatic pulse_start(input int len, input int chc, input bit with_stop);
        @(posedge clk); #1;
        init_len = len[AW:0]; ch_count = chc[6:0]; start = 1'b1; stop = with_stop;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        // Changing the controls mid-run must not matter.
        init_len = 5'($urandom_range(31)); ch_count = 7'($urandom_range(127));
    endtask

    task automatic run(input int len, input int chc, input int nframes, input int pct,
                       input int stop_off, input bit inject, input bit same_stop);
        int eff_len, eff_ch, k, a0, off;
        eff_len = (len > INIT_DEPTH) ? INIT_DEPTH : len;
        eff_ch  = (chc == 0 || chc > NUM_CH) ? NUM_CH : chc;
        off = stop_off;
        if (off < 0) off = (eff_ch > 1) ? int'($urandom_range(eff_ch - 1, 1)) : 0;
        k = eff_len + 2 + (nframes - 1) * eff_ch + off;
        ready_pct = pct;
        a0 = acc_cnt;
        push_run(eff_len, eff_ch, nframes);
        pulse_start(len, chc, same_stop);
        check("busy_after_start", 32'(busy), 32'd1);
        if (inject) begin
            wait_acc(a0 + eff_len + 3);
            cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = ~mem_model[0]; start = 1'b1;
            @(posedge clk); #1;
            cfg_we = 1'b0; start = 1'b0;
        end
        wait_acc(a0 + k);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("idle_state", 32'(state_o), 32'd0);
        frames_tot += nframes;
        check("frame_cnt_total", frame_cnt, 32'(frames_tot));
        ready_pct = 100;
    endtask

    // Stop during INIT entry 1 while the engine stalls.
    task automatic stop_in_init();
        int a0;
        manual = 1'b1;
        cmd_ready = 1'b0;
        a0 = acc_cnt;
        exp_q.push_back('{data: mem_model[0], st: 2'd1, first: 1'b0, last: 1'b0, fin: 1'b0});
        exp_q.push_back('{data: mem_model[1], st: 2'd1, first: 1'b0, last: 1'b0, fin: 1'b1});
        pulse_start(3, 4, 1'b0);
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("init_stall_busy", 32'(busy), 32'd1);
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("init_stop_idle", 32'(state_o), 32'd0);
        check("init_stop_count", 32'(acc_cnt - a0), 32'd2);
        check("init_stop_queue", 32'(exp_q.size()), 32'd0);
        manual = 1'b0;
    endtask

    task automatic reset_mid_acq();
        int a0;
        ready_pct = 100;
        a0 = acc_cnt;
        push_run(3, 4, 3);
        pulse_start(3, 4, 1'b0);
        wait_acc(a0 + 3 + 2 + 5);
        check("valid_before_reset", 32'(cmd_valid), 32'd1);
        do_reset();
    endtask

    initial begin
        int len, chc;
        do_reset();
        write_cfg(0, 16'h8011);
        write_cfg(1, 16'h8122);
        write_cfg(2, 16'h8233);
        for (int i = 3; i < INIT_DEPTH; i++) write_cfg(i, 16'($urandom));

        run(3, 4, 2, 100, -1, 1'b0, 1'b0);        // basic sequence
        do_reset();
        run(0, 0, 1, 100, -1, 1'b0, 1'b0);        // no init, default channel count
        run(20, 100, 1, 100, -1, 1'b0, 1'b0);     // both controls clamped
        do_reset();
        run(int'($urandom_range(16, 1)), 4, 5, 50, -1, 1'b0, 1'b0);  // backpressure
        do_reset();
        run(3, 4, 3, 100, 1, 1'b0, 1'b0);         // stop while CONVERT(1) of frame 3
        stop_in_init();
        run(3, 4, 2, 100, -1, 1'b1, 1'b0);        // start/cfg_we while busy ignored
        run(3, 4, 2, 70, -1, 1'b0, 1'b1);         // start+stop together, old entry 0
        reset_mid_acq();
        run(3, 4, 1, 100, -1, 1'b0, 1'b0);        // full replay after reset
        for (int r = 0; r < 4; r++) begin
            len = int'($urandom_range(20));
            chc = int'($urandom_range(70));
            if (chc == 1) chc = 2;
            run(len, chc, int'($urandom_range(3, 1)), int'($urandom_range(100, 30)), -1, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
